// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter between the CPU MEM stage and a DMA requester.
// CPU has default priority; DMA is forced in after MAX_WAIT starved cycles and bursts at most BURST beats.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned BURST    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT) + 1;
  localparam int unsigned BW = $clog2(BURST) + 1;

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  owner_t        r_owner;
  logic [WW-1:0] r_wait_cnt;
  logic [BW-1:0] r_beat_cnt;

  logic w_dma_own;
  logic w_wait_lim;
  logic w_beat_lim;
  logic w_to_dma;
  logic w_to_cpu;

  assign w_dma_own  = (r_owner == OWN_DMA);
  assign w_wait_lim = (r_wait_cnt == WW'(MAX_WAIT - 1));
  assign w_beat_lim = (r_beat_cnt == BW'(BURST - 1));
  assign w_to_dma   = !w_dma_own && dma_req && (!cpu_req || w_wait_lim);
  // The beat in flight always completes; the CPU takes the port on the next edge.
  assign w_to_cpu   = w_dma_own && (!dma_req || cpu_req || w_beat_lim);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= OWN_CPU;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_owner)
        OWN_CPU: begin
          r_beat_cnt <= '0;
          if (w_to_dma) begin
            r_owner    <= OWN_DMA;
            r_wait_cnt <= '0;
          end else if (dma_req && cpu_req) begin
            if (!w_wait_lim) r_wait_cnt <= r_wait_cnt + WW'(1);
          end else begin
            r_wait_cnt <= '0;
          end
        end
        OWN_DMA: begin
          r_wait_cnt <= '0;
          if (w_to_cpu) begin
            r_owner    <= OWN_CPU;
            r_beat_cnt <= '0;
          end else if (dma_req && !w_beat_lim) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        default: r_owner <= OWN_CPU;
      endcase
    end
  end

  // Strobes and handshakes are suppressed during reset so an in-flight beat is aborted.
  always_comb begin
    mem_addr  = w_dma_own ? dma_addr  : cpu_addr;
    mem_wdata = w_dma_own ? dma_wdata : cpu_wdata;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    dma_ack   = 1'b0;
    cpu_stall = 1'b0;
    if (!reset) begin
      if (w_dma_own) begin
        mem_rd    = dma_req && !dma_wr;
        mem_wr    = dma_req && dma_wr;
        dma_ack   = dma_req;
        cpu_stall = cpu_req;
      end else begin
        mem_rd = cpu_req && !cpu_wr;
        mem_wr = cpu_req && cpu_wr;
      end
    end
  end

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a cycle-level reference model with a reference memory.
module tb_dmem_arbiter;

  localparam int unsigned MW = 8;
  localparam int unsigned BU = 4;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MAX_WAIT(MW), .BURST(BU)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM: combinational read, write on the clock edge
  logic [31:0] ram [64];
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr) ram[mem_addr[7:2]] <= mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // in = {reset, cpu_req, cpu_wr, dma_req, dma_wr}; ex = {ack, stall, mem_rd, mem_wr, check_rdata}
  typedef struct {
    logic [4:0]  in;
    logic [31:0] caddr, cwd, daddr, dwd;
    logic [4:0]  ex;
    logic [31:0] eaddr, erd;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] caddr, cwd, daddr, dwd,
                              input logic [4:0] ex, input logic [31:0] eaddr, erd);
    vec_t v;
    v.in = in; v.caddr = caddr; v.cwd = cwd; v.daddr = daddr; v.dwd = dwd;
    v.ex = ex; v.eaddr = eaddr; v.erd = erd;
    return v;
  endfunction

  // Drive one cycle, compare at the falling edge, advance past the next rising edge.
  task automatic apply_vec(input vec_t v, input string tag);
    {reset, cpu_req, cpu_wr, dma_req, dma_wr} = v.in;
    cpu_addr = v.caddr; cpu_wdata = v.cwd; dma_addr = v.daddr; dma_wdata = v.dwd;
    #4;
    chk({tag, ".ack"},   32'(dma_ack),   32'(v.ex[4]));
    chk({tag, ".stall"}, 32'(cpu_stall), 32'(v.ex[3]));
    chk({tag, ".rd"},    32'(mem_rd),    32'(v.ex[2]));
    chk({tag, ".wr"},    32'(mem_wr),    32'(v.ex[1]));
    if (v.ex[2] || v.ex[1]) chk({tag, ".addr"}, mem_addr, v.eaddr);
    if (v.ex[1]) chk({tag, ".wdata"}, mem_wdata, v.ex[4] ? v.dwd : v.cwd);
    if (v.ex[0]) begin
      chk({tag, ".cpu_rdata"}, cpu_rdata, v.erd);
      chk({tag, ".dma_rdata"}, dma_rdata, v.erd);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  // reference model state for the random phase
  bit          m_dma;
  int unsigned m_wait, m_beats;
  logic [31:0] refm [64];
  bit          refv [64];
  bit          c_hold, d_hold;
  logic        e_ack, e_stall, e_rd, e_wr;
  logic [31:0] e_addr, e_wd;
  logic [5:0]  idx;
  logic [8:0]  ack_pat;
  int unsigned beat, wi;
  bit          a;

  initial begin
    {reset, cpu_req, cpu_wr, dma_req, dma_wr} = 5'b10000;
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
    @(posedge clk);
    #1;

    // ---------------- directed table ----------------
    tbl.push_back(mk(5'b1_11_11, 32'h10, 32'hdead, 32'h10, 32'hbeef, 5'b00_00_0, 32'h0,  32'h0));
    tbl.push_back(mk(5'b0_11_00, 32'h10, 32'h1234, 32'h0,  32'h0,    5'b00_01_0, 32'h10, 32'h0));
    tbl.push_back(mk(5'b0_10_00, 32'h10, 32'h0,    32'h0,  32'h0,    5'b00_10_1, 32'h10, 32'h1234));
    tbl.push_back(mk(5'b0_00_11, 32'h0,  32'h0,    32'h20, 32'ha5a5, 5'b00_00_0, 32'h0,  32'h0));
    tbl.push_back(mk(5'b0_00_11, 32'h0,  32'h0,    32'h20, 32'ha5a5, 5'b10_01_0, 32'h20, 32'h0));
    tbl.push_back(mk(5'b0_00_00, 32'h0,  32'h0,    32'h0,  32'h0,    5'b00_00_0, 32'h0,  32'h0));
    tbl.push_back(mk(5'b0_10_00, 32'h20, 32'h0,    32'h0,  32'h0,    5'b00_10_1, 32'h20, 32'ha5a5));
    tbl.push_back(mk(5'b0_00_11, 32'h0,  32'h0,    32'h30, 32'h1111, 5'b00_00_0, 32'h0,  32'h0));
    tbl.push_back(mk(5'b0_00_11, 32'h0,  32'h0,    32'h30, 32'h1111, 5'b10_01_0, 32'h30, 32'h0));
    tbl.push_back(mk(5'b1_00_11, 32'h0,  32'h0,    32'h10, 32'h0bad, 5'b00_00_0, 32'h0,  32'h0));
    tbl.push_back(mk(5'b0_10_00, 32'h10, 32'h0,    32'h0,  32'h0,    5'b00_10_1, 32'h10, 32'h1234));
    tbl.push_back(mk(5'b0_10_00, 32'h30, 32'h0,    32'h0,  32'h0,    5'b00_10_1, 32'h30, 32'h1111));
    tbl.push_back(mk(5'b0_10_10, 32'h20, 32'h0,    32'h30, 32'h0,    5'b00_10_1, 32'h20, 32'ha5a5));
    tbl.push_back(mk(5'b0_00_10, 32'h0,  32'h0,    32'h30, 32'h0,    5'b00_00_0, 32'h0,  32'h0));
    tbl.push_back(mk(5'b0_00_10, 32'h0,  32'h0,    32'h30, 32'h0,    5'b10_10_1, 32'h30, 32'h1111));
    tbl.push_back(mk(5'b0_00_00, 32'h0,  32'h0,    32'h0,  32'h0,    5'b00_00_0, 32'h0,  32'h0));
    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // ---------------- DMA burst of 6 beats, BURST=4 ----------------
    ack_pat = 9'b0_1101_1110;
    beat = 0;
    for (int c = 0; c < 9; c++) begin
      a = ack_pat[c];
      apply_vec(mk({3'b000, beat < 6, 1'b1}, 32'h0, 32'h0, 32'(beat * 4), 32'h100 + 32'(beat),
                   {a, 1'b0, 1'b0, a, 1'b0}, 32'(beat * 4), 32'h0), $sformatf("burst_c%0d", c));
      if (a) beat++;
    end
    for (int i = 0; i < 6; i++)
      apply_vec(mk(5'b0_10_00, 32'(i * 4), 32'h0, 32'h0, 32'h0, 5'b00_10_1, 32'(i * 4),
                   32'h100 + 32'(i)), $sformatf("burst_rb%0d", i));

    // ---------------- starvation, MAX_WAIT=8 ----------------
    wi = 0;
    for (int c = 0; c < 10; c++) begin
      a = (c == 8);
      apply_vec(mk({3'b011, c <= 8, 1'b1}, 32'h80 + 32'(wi * 4), 32'h200 + 32'(wi), 32'h60, 32'h77,
                   {a, a, 1'b0, 1'b1, 1'b0}, a ? 32'h60 : 32'h80 + 32'(wi * 4), 32'h0),
                $sformatf("starve_c%0d", c));
      if (!a) wi++;
    end
    chk("starve_cpu_accesses", wi, 9);
    for (int i = 0; i < 9; i++)
      apply_vec(mk(5'b0_10_00, 32'h80 + 32'(i * 4), 32'h0, 32'h0, 32'h0, 5'b00_10_1,
                   32'h80 + 32'(i * 4), 32'h200 + 32'(i)), $sformatf("starve_rb%0d", i));
    apply_vec(mk(5'b0_10_00, 32'h60, 32'h0, 32'h0, 32'h0, 5'b00_10_1, 32'h60, 32'h77), "starve_rb_dma");

    // ---------------- CPU arrives mid-burst ----------------
    apply_vec(mk(5'b0_00_11, 32'h0,  32'h0, 32'hc0, 32'h300, 5'b00_00_0, 32'h0,  32'h0),   "mid_c0");
    apply_vec(mk(5'b0_00_11, 32'h0,  32'h0, 32'hc0, 32'h300, 5'b10_01_0, 32'hc0, 32'h0),   "mid_c1");
    apply_vec(mk(5'b0_10_11, 32'h80, 32'h0, 32'hc4, 32'h301, 5'b11_01_0, 32'hc4, 32'h0),   "mid_k");
    apply_vec(mk(5'b0_10_11, 32'h80, 32'h0, 32'hc8, 32'h302, 5'b00_10_1, 32'h80, 32'h200), "mid_k1");
    apply_vec(mk(5'b0_00_11, 32'h0,  32'h0, 32'hc8, 32'h302, 5'b00_00_0, 32'h0,  32'h0),   "mid_c4");
    apply_vec(mk(5'b0_00_11, 32'h0,  32'h0, 32'hc8, 32'h302, 5'b10_01_0, 32'hc8, 32'h0),   "mid_c5");
    apply_vec(mk(5'b0_00_00, 32'h0,  32'h0, 32'h0,  32'h0,   5'b00_00_0, 32'h0,  32'h0),   "mid_c6");
    apply_vec(mk(5'b0_10_00, 32'hc4, 32'h0, 32'h0,  32'h0,   5'b00_10_1, 32'hc4, 32'h301), "mid_rb");

    // ---------------- randomized traffic vs reference model ----------------
    m_dma = 0; m_wait = 0; m_beats = 0; c_hold = 0; d_hold = 0;
    foreach (refv[i]) refv[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = (n == 0) || ($urandom_range(0, 99) == 0);
      if (!c_hold) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_wr    = ($urandom_range(0, 1) != 0);
        cpu_addr  = $urandom_range(0, 63) << 2;
        cpu_wdata = $urandom;
      end
      if (!d_hold) begin
        dma_req   = ($urandom_range(0, 9) < 4);
        dma_wr    = ($urandom_range(0, 1) != 0);
        dma_addr  = $urandom_range(0, 63) << 2;
        dma_wdata = $urandom;
      end
      #4;
      e_ack = 0; e_stall = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      if (!reset) begin
        if (m_dma) begin
          e_ack = dma_req; e_stall = cpu_req;
          e_rd = dma_req && !dma_wr; e_wr = dma_req && dma_wr;
          e_addr = dma_addr; e_wd = dma_wdata;
        end else begin
          e_rd = cpu_req && !cpu_wr; e_wr = cpu_req && cpu_wr;
          e_addr = cpu_addr; e_wd = cpu_wdata;
        end
      end
      chk("rnd.ack",   32'(dma_ack),   32'(e_ack));
      chk("rnd.stall", 32'(cpu_stall), 32'(e_stall));
      chk("rnd.rd",    32'(mem_rd),    32'(e_rd));
      chk("rnd.wr",    32'(mem_wr),    32'(e_wr));
      if (e_rd || e_wr) chk("rnd.addr", mem_addr, e_addr);
      if (e_wr) chk("rnd.wdata", mem_wdata, e_wd);
      idx = e_addr[7:2];
      if (e_rd && refv[idx]) begin
        if (m_dma) chk("rnd.dma_rdata", dma_rdata, refm[idx]);
        else       chk("rnd.cpu_rdata", cpu_rdata, refm[idx]);
      end
      if (e_wr) begin
        refm[idx] = e_wd;
        refv[idx] = 1;
      end
      if (reset) begin
        m_dma = 0; m_wait = 0; m_beats = 0;
      end else if (!m_dma) begin
        if (dma_req && (!cpu_req || m_wait == MW - 1)) begin
          m_dma = 1; m_wait = 0;
        end else if (dma_req && cpu_req) begin
          if (m_wait < MW - 1) m_wait++;
        end else begin
          m_wait = 0;
        end
      end else begin
        if (dma_req) m_beats++;
        if (!dma_req || cpu_req || m_beats == BU) begin
          m_dma = 0; m_beats = 0;
        end
      end
      c_hold = e_stall;
      d_hold = dma_req && !e_ack && !reset;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
